// File: rtl/pio_mc_pkg.sv
// Shared definitions for the multi-channel PIO: register map, edge modes,
// post-reset arming length and address sizing helper.
package pio_mc_pkg;

    typedef enum logic [2:0] {
        REG_DATA    = 3'd0,
        REG_INPUT   = 3'd1,
        REG_IRQMASK = 3'd2,
        REG_EDGECAP = 3'd3,
        REG_OUTSET  = 3'd4,
        REG_OUTCLR  = 3'd5,
        REG_RSVD6   = 3'd6,
        REG_RSVD7   = 3'd7
    } reg_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam logic [1:0] ARM_CYCLES = 2'd3;

    // Channel field is never narrower than one bit, even for a single channel.
    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pio_edge_chan.sv
// One PIO channel input path: 2-flop synchroniser, previous-value register,
// edge detect and the sticky edge-capture register with write-1-to-clear.
module pio_edge_chan
    import pio_mc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_port,
    input  logic              arm,
    input  logic              clr_we,
    input  logic [DATA_W-1:0] clr_mask,
    output logic [DATA_W-1:0] in_sync,
    output logic [DATA_W-1:0] cap
);

    logic [DATA_W-1:0] s0, s1, prev, hit, clr;

    always_comb begin
        hit = s1 & ~prev;
        if (EDGE_TYPE == EDGE_FALL)
            hit = ~s1 & prev;
        else if (EDGE_TYPE == EDGE_ANY)
            hit = s1 ^ prev;
    end

    assign clr     = clr_we ? clr_mask : '0;
    assign in_sync = s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0   <= '0;
            s1   <= '0;
            prev <= '0;
            cap  <= '0;
        end else begin
            s0   <= in_port;
            s1   <= s0;
            prev <= s1;
            // New edges are ORed after the clear so a coincident edge survives.
            cap  <= (cap & ~clr) | (arm ? hit : '0);
        end
    end

endmodule

// File: rtl/pio_mc_edge.sv
// Multi-channel Avalon-MM PIO slave: bus decode, output/mask registers,
// two-stage read path, arming counter and the registered interrupt.
module pio_mc_edge
    import pio_mc_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          CHANNELS  = 4,
    parameter int          EDGE_TYPE = EDGE_RISE,
    parameter logic [31:0] OUT_RESET = 32'h0,
    localparam int         CHAN_W    = chan_bits(CHANNELS),
    localparam int         ADDR_W    = CHAN_W + 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic                       read_n,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    input  logic [CHANNELS*DATA_W-1:0] in_port,
    output logic [CHANNELS*DATA_W-1:0] out_port,
    output logic                       irq
);

    logic [CHAN_W-1:0]                chan;
    reg_e                             rsel;
    logic [CHANNELS-1:0]              chan_sel;
    logic                             wr, rd, arm, rd_pend;
    logic [DATA_W-1:0]                wdata, rd_mux;
    logic [31:0]                      rd_ext, rd_buf;
    logic [1:0]                       arm_cnt;
    logic [CHANNELS-1:0][DATA_W-1:0]  data_q, mask_q, in_sync, cap;

    assign chan  = address[ADDR_W-1:3];
    assign rsel  = reg_e'(address[2:0]);
    assign wr    = chipselect & ~write_n;
    assign rd    = chipselect & ~read_n;
    assign wdata = writedata[DATA_W-1:0];
    assign arm   = (arm_cnt == ARM_CYCLES);

    // Out-of-range channel numbers match no select line, so they read 0 and ignore writes.
    always_comb begin
        chan_sel = '0;
        for (int c = 0; c < CHANNELS; c++)
            chan_sel[c] = (chan == CHAN_W'(c));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                data_q[c] <= OUT_RESET[DATA_W-1:0];
            mask_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr && chan_sel[c]) begin
                    case (rsel)
                        REG_DATA:    data_q[c] <= wdata;
                        REG_IRQMASK: mask_q[c] <= wdata;
                        REG_OUTSET:  data_q[c] <= data_q[c] | wdata;
                        REG_OUTCLR:  data_q[c] <= data_q[c] & ~wdata;
                        default:     ;
                    endcase
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_chan
            pio_edge_chan #(
                .DATA_W    (DATA_W),
                .EDGE_TYPE (EDGE_TYPE)
            ) u_chan (
                .clk      (clk),
                .reset    (reset),
                .in_port  (in_port[g*DATA_W +: DATA_W]),
                .arm      (arm),
                .clr_we   (wr && chan_sel[g] && rsel == REG_EDGECAP),
                .clr_mask (wdata),
                .in_sync  (in_sync[g]),
                .cap      (cap[g])
            );
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_sel[c]) begin
                case (rsel)
                    REG_DATA:    rd_mux = data_q[c];
                    REG_INPUT:   rd_mux = in_sync[c];
                    REG_IRQMASK: rd_mux = mask_q[c];
                    REG_EDGECAP: rd_mux = cap[c];
                    default:     ;
                endcase
            end
        end
        rd_ext             = '0;
        rd_ext[DATA_W-1:0] = rd_mux;
    end

    // Snapshot at the strobe edge gives pre-write data; it is presented one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_buf   <= '0;
            readdata <= '0;
        end else begin
            rd_pend <= rd;
            if (rd)
                rd_buf <= rd_ext;
            if (rd_pend)
                readdata <= rd_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt <= '0;
            irq     <= 1'b0;
        end else begin
            if (!arm)
                arm_cnt <= arm_cnt + 2'd1;
            irq <= |(cap & mask_q);
        end
    end

    assign out_port = data_q;

endmodule

// File: tb/tb_pio_mc_edge.sv
// Directed bench for pio_mc_edge with 3 x 32-bit rising-edge channels, so that
// channel number 3 is an addressable out-of-range channel.
module tb_pio_mc_edge;

    localparam int          DATA_W   = 32;
    localparam int          CHANNELS = 3;
    localparam int          ADDR_W   = 5;
    localparam logic [31:0] OUT_RST  = 32'h0000_1111;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [ADDR_W-1:0]          address;
    logic                       chipselect, write_n, read_n;
    logic [31:0]                writedata, readdata;
    logic [CHANNELS*DATA_W-1:0] in_port, out_port;
    logic                       irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rv;

    pio_mc_edge #(
        .DATA_W    (DATA_W),
        .CHANNELS  (CHANNELS),
        .EDGE_TYPE (0),
        .OUT_RESET (OUT_RST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] adr(input int ch, input int r);
        return {2'(ch), 3'(r)};
    endfunction

    function automatic logic [31:0] outc(input int ch);
        return out_port[ch*DATA_W +: DATA_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
        tick();
        d = readdata;
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (3) tick();
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_out0", outc(0), OUT_RST);
        reset = 1'b0;
        repeat (4) tick();

        // Test 1: full-word DATA write on channel 2
        bus_write(adr(2, 0), 32'hA5A5_0000);
        chk("t1_out2", outc(2), 32'hA5A5_0000);
        chk("t1_out0", outc(0), OUT_RST);
        chk("t1_out1", outc(1), OUT_RST);

        // Test 2: set/clear on channel 0, readback and hold
        bus_write(adr(0, 0), 32'h0000_000F);
        bus_write(adr(0, 4), 32'h0000_00F0);
        chk("t2_outset", outc(0), 32'h0000_00FF);
        bus_write(adr(0, 5), 32'h0000_0030);
        chk("t2_outclr", outc(0), 32'h0000_00CF);
        address = adr(0, 0); chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
        chk("t2_rd_not_yet", readdata, 32'h0);
        tick();
        chk("t2_rd_data", readdata, 32'h0000_00CF);
        tick();
        chk("t2_rd_hold", readdata, 32'h0000_00CF);
        bus_read(adr(0, 4), rv);
        chk("t2_rd_outset_wo", rv, 32'h0);
        bus_write(adr(0, 6), 32'hFFFF_FFFF);
        bus_read(adr(0, 6), rv);
        chk("t2_rd_rsvd", rv, 32'h0);

        // Test 3: rising edge ch1 bit3, irq timing and W1C
        bus_write(adr(1, 2), 32'h0000_0008);
        in_port[1*DATA_W + 3] = 1'b1;
        tick();
        chk("t3_irq_k", {31'h0, irq}, 32'h0);
        tick();
        chk("t3_irq_k1", {31'h0, irq}, 32'h0);
        tick();
        chk("t3_irq_k2", {31'h0, irq}, 32'h0);
        tick();
        chk("t3_irq_k3", {31'h0, irq}, 32'h1);
        bus_read(adr(1, 3), rv);
        chk("t3_edgecap", rv, 32'h0000_0008);
        bus_read(adr(1, 1), rv);
        chk("t3_input", rv, 32'h0000_0008);
        bus_write(adr(1, 3), 32'h0000_0008);
        chk("t3_irq_lag", {31'h0, irq}, 32'h1);
        tick();
        chk("t3_irq_drop", {31'h0, irq}, 32'h0);
        bus_read(adr(1, 3), rv);
        chk("t3_edgecap_clr", rv, 32'h0);

        // Test 5: edge and W1C on the same bit in the same cycle
        in_port[0] = 1'b1;
        tick();
        tick();
        bus_write(adr(0, 3), 32'h0000_0001);
        bus_read(adr(0, 3), rv);
        chk("t5_set_wins", rv, 32'h0000_0001);
        bus_write(adr(0, 3), 32'h0000_0001);
        bus_read(adr(0, 3), rv);
        chk("t5_w1c_alone", rv, 32'h0);
        bus_read(adr(2, 0), rv);
        chk("t5_rd_ch2", rv, 32'hA5A5_0000);
        bus_read(adr(3, 0), rv);
        chk("t5_rd_badchan", rv, 32'h0);
        bus_write(adr(3, 0), 32'hFFFF_FFFF);
        chk("t5_badwr_out0", outc(0), 32'h0000_00CF);
        chk("t5_badwr_out1", outc(1), OUT_RST);
        chk("t5_badwr_out2", outc(2), 32'hA5A5_0000);

        // Simultaneous write and read: read returns the pre-write value
        address = adr(1, 0); writedata = 32'hDEAD_BEEF;
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        tick();
        chk("rw_prewrite", readdata, OUT_RST);
        chk("rw_out1", outc(1), 32'hDEAD_BEEF);

        // Test 6: reset one cycle after a read strobe
        bus_write(adr(1, 2), 32'h0000_000F);
        in_port[1*DATA_W + 0] = 1'b1;
        repeat (5) tick();
        chk("t6_irq_pre", {31'h0, irq}, 32'h1);
        address = adr(2, 0); chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1; reset = 1'b1;
        tick();
        chk("t6_readdata", readdata, 32'h0);
        chk("t6_irq", {31'h0, irq}, 32'h0);
        chk("t6_out0", outc(0), OUT_RST);
        chk("t6_out1", outc(1), OUT_RST);
        chk("t6_out2", outc(2), OUT_RST);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        bus_read(adr(1, 2), rv);
        chk("t6_mask", rv, 32'h0);
        bus_read(adr(1, 3), rv);
        chk("t6_edgecap", rv, 32'h0);

        // Test 4: inputs high through reset release are not captured
        in_port = '1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (6) tick();
        for (int c = 0; c < CHANNELS; c++) begin
            bus_read(adr(c, 3), rv);
            chk($sformatf("t4_arm_cap%0d", c), rv, 32'h0);
        end
        bus_read(adr(2, 1), rv);
        chk("t4_input", rv, 32'hFFFF_FFFF);
        in_port = '0;
        repeat (5) tick();
        bus_read(adr(0, 3), rv);
        chk("t4_fall_ignored", rv, 32'h0);
        in_port[2*DATA_W + 31] = 1'b1;
        repeat (4) tick();
        bus_read(adr(2, 3), rv);
        chk("t4_armed_rise", rv, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
